// File: rtl/fir_channel_scheduler.sv
// rtl/fir_channel_scheduler.sv - round-robin job scheduler sharing one serial-MAC FIR engine across channels

module fir_channel_scheduler #(
    parameter int NUM_CH         = 2,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_CH-1:0]    sample_valid_in,
    input  logic [16*NUM_CH-1:0] sample_in,
    input  logic                 ovr_clr_in,
    output logic                 fir_ready_out,
    output logic [15:0]          fir_sample_out,
    output logic [CH_W-1:0]      fir_chan_out,
    input  logic                 fir_done_in,
    input  logic [15:0]          fir_result_in,
    output logic                 result_valid_out,
    output logic [CH_W-1:0]      result_chan_out,
    output logic [15:0]          result_out,
    output logic [NUM_CH-1:0]    overrun_out,
    output logic                 timeout_out,
    output logic                 busy_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t             state;
    logic [NUM_CH-1:0]  pending;
    logic [15:0]        pend_data [NUM_CH];
    logic [CH_W-1:0]    last_grant;
    logic [TW-1:0]      timer;

    logic               grant_found;
    logic [CH_W-1:0]    grant_idx;
    logic               grant_fire;
    logic [NUM_CH-1:0]  grant_mask;
    logic [NUM_CH-1:0]  new_ovr;

    // Find the first pending channel after the last one served, wrapping around
    always_comb begin
        int              cand;
        logic [CH_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand     = (int'(last_grant) + i) % NUM_CH;
            cand_idx = CH_W'(cand);
            if (!grant_found && pending[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // A grant only happens from IDLE; the mask lets a same-cycle strobe re-arm the channel without overrun
    always_comb begin
        grant_fire = (state == IDLE) && grant_found;
        grant_mask = '0;
        if (grant_fire) begin
            grant_mask[grant_idx] = 1'b1;
        end
        new_ovr = sample_valid_in & pending & ~grant_mask;
    end

    // Pending sample store and sticky overrun flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending     <= '0;
            overrun_out <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                pend_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sample_valid_in[k]) begin
                    pend_data[k] <= sample_in[16*k +: 16];
                end
            end
            pending     <= (pending & ~grant_mask) | sample_valid_in;
            overrun_out <= (ovr_clr_in ? '0 : overrun_out) | new_ovr;
        end
    end

    // Job sequencing: grant, start pulse, wait for done or timeout, capture result
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            last_grant       <= CH_W'(NUM_CH - 1);
            timer            <= '0;
            fir_ready_out    <= 1'b0;
            fir_sample_out   <= '0;
            fir_chan_out     <= '0;
            result_valid_out <= 1'b0;
            result_chan_out  <= '0;
            result_out       <= '0;
            timeout_out      <= 1'b0;
        end else begin
            fir_ready_out    <= 1'b0;
            result_valid_out <= 1'b0;
            timeout_out      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        fir_chan_out   <= grant_idx;
                        fir_sample_out <= pend_data[grant_idx];
                        last_grant     <= grant_idx;
                        fir_ready_out  <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fir_done_in) begin
                        state <= CAPTURE;
                    end else if (timer + 1'b1 == TIMER_LAST) begin
                        timer       <= '0;
                        timeout_out <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CAPTURE: begin
                    result_out       <= fir_result_in;
                    result_chan_out  <= fir_chan_out;
                    result_valid_out <= 1'b1;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_out = (state != IDLE);

endmodule
